alu_regfile_exec: RTL and testbench

- Single-clock execute/writeback slice for a 32-bit MIPS-style core: a 32x32 register file plus a combinational ALU.
- One decoded-in-place instruction is accepted per cycle. Operands are read asynchronously, the result is computed, and it is written back to the register file on the same rising edge.
- Sits downstream of instruction fetch. It replaces the separate clock/RegisterFile/ALU trio with one reset-able block.

---
 rtl/alu_regfile_exec_if.sv | 21 ++
 rtl/alu_regfile_exec.sv | 94 +++++++++
 tb/tb_alu_regfile_exec.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_regfile_exec_if.sv
// alu_regfile_exec_if: instruction, result and debug-read signals of the execute/writeback slice.
interface alu_regfile_exec_if;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] result;
  logic        result_valid;
  logic        illegal;
  logic        ovf;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  modport master (
    output instr_valid, instruction, dbg_addr,
    input  alu_result, zero, result, result_valid, illegal, ovf, dbg_data
  );
  modport slave (
    input  instr_valid, instruction, dbg_addr,
    output alu_result, zero, result, result_valid, illegal, ovf, dbg_data
  );
endinterface

// File: rtl/alu_regfile_exec.sv
// alu_regfile_exec: 32x32 register file plus combinational ALU, single-cycle execute/writeback.
// Define OVF_TRAP_EN to suppress writeback and pulse ovf on signed add/sub/addi overflow.
module alu_regfile_exec #(
  parameter logic [31:0] REG_RESET_VAL = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n,
  alu_regfile_exec_if.slave bus
);
  logic [31:0] regs [32];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, dest;
  logic [15:0] imm;
  logic [31:0] a, b, sum, diff, alu;
  logic        legal, ovf_hit, do_write;
  assign op    = bus.instruction[31:26];
  assign rs    = bus.instruction[25:21];
  assign rt    = bus.instruction[20:16];
  assign rd    = bus.instruction[15:11];
  assign shamt = bus.instruction[10:6];
  assign funct = bus.instruction[5:0];
  assign imm   = bus.instruction[15:0];
  assign a = rs == 5'd0 ? 32'd0 : regs[rs];
  // Logical immediates zero-extend; arithmetic and compare immediates sign-extend.
  assign b = op == 6'h00 ? (rt == 5'd0 ? 32'd0 : regs[rt])
           : (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {16'd0, imm}
           : {{16{imm[15]}}, imm};
  assign sum  = a + b;
  assign diff = a - b;
  always_comb begin
    alu   = '0;
    legal = 1'b1;
    dest  = rt;
    if (op == 6'h00) begin
      dest = rd;
      case (funct)
        6'h20, 6'h21: alu = sum;
        6'h22, 6'h23: alu = diff;
        6'h24:        alu = a & b;
        6'h25:        alu = a | b;
        6'h26:        alu = a ^ b;
        6'h27:        alu = ~(a | b);
        6'h2A:        alu = {31'd0, $signed(a) < $signed(b)};
        6'h2B:        alu = {31'd0, a < b};
        6'h00:        alu = b << shamt;
        6'h02:        alu = b >> shamt;
        6'h03:        alu = $signed(b) >>> shamt;
        default:      legal = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: alu = sum;
        6'h0A:        alu = {31'd0, $signed(a) < $signed(b)};
        6'h0B:        alu = {31'd0, a < b};
        6'h0C:        alu = a & b;
        6'h0D:        alu = a | b;
        6'h0E:        alu = a ^ b;
        6'h0F:        alu = {imm, 16'd0};
        default:      legal = 1'b0;
      endcase
    end
  end
`ifdef OVF_TRAP_EN
  logic add_ovf, sub_ovf;
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
  assign ovf_hit = (op == 6'h00 && funct == 6'h20 && add_ovf)
                || (op == 6'h00 && funct == 6'h22 && sub_ovf)
                || (op == 6'h08 && add_ovf);
`else
  assign ovf_hit = 1'b0;
`endif
  assign do_write       = bus.instr_valid && legal && !ovf_hit;
  assign bus.alu_result = alu;
  assign bus.zero       = alu == 32'd0;
  assign bus.dbg_data   = bus.dbg_addr == 5'd0 ? 32'd0 : regs[bus.dbg_addr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= i == 0 ? 32'd0 : REG_RESET_VAL;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
      bus.illegal      <= 1'b0;
      bus.ovf          <= 1'b0;
    end else begin
      bus.result_valid <= do_write;
      bus.illegal      <= bus.instr_valid && !legal;
      bus.ovf          <= bus.instr_valid && legal && ovf_hit;
      if (do_write) begin
        bus.result <= alu;
        if (dest != 5'd0) regs[dest] <= alu;
      end
    end
  end
endmodule

// File: tb/tb_alu_regfile_exec.sv
// tb_alu_regfile_exec: directed vectors with hand-computed expectations for alu_regfile_exec.
module tb_alu_regfile_exec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  alu_regfile_exec_if bus ();
  alu_regfile_exec dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reg_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.dbg_addr = addr;
    #1;
    check(tag, bus.dbg_data, exp);
  endtask

  // Drive at the falling edge, check combinational ALU, then check registered outputs after the rise.
  task automatic exec(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] exp_alu,
                      input logic exp_rv, input logic exp_ill, input logic exp_ovf, input logic [31:0] exp_res);
    @(negedge clk);
    bus.instr_valid = v;
    bus.instruction = ins;
    #1;
    check({tag, "_alu"}, bus.alu_result, exp_alu);
    check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, exp_alu == 32'd0});
    @(posedge clk);
    #1;
    check({tag, "_rv"}, {31'd0, bus.result_valid}, {31'd0, exp_rv});
    check({tag, "_ill"}, {31'd0, bus.illegal}, {31'd0, exp_ill});
    check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
    check({tag, "_res"}, bus.result, exp_res);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instruction = 32'd0;
    bus.dbg_addr    = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_result", bus.result, 32'd0);
    check("rst_rv", {31'd0, bus.result_valid}, 32'd0);
    check("rst_ill", {31'd0, bus.illegal}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);

    exec("pre_addi", 1'b1, 32'h2001_0005, 32'd5, 1'b1, 1'b0, 1'b0, 32'd5);
    reg_check("pre_r1", 5'd1, 32'd5);

    // Reset asserted mid-cycle while a valid write is pending: the write must be lost.
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instruction = 32'h2002_0009;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("mid_rst_result", bus.result, 32'd0);
    check("mid_rst_rv", {31'd0, bus.result_valid}, 32'd0);
    for (int i = 0; i < 32; i++) reg_check($sformatf("mid_rst_r%0d", i), 5'(i), 32'd0);

    exec("addi_r1", 1'b1, 32'h2001_0005, 32'd5, 1'b1, 1'b0, 1'b0, 32'd5);
    exec("addi_r2", 1'b1, 32'h2002_FFFD, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD);
    exec("add_r3", 1'b1, 32'h0022_1820, 32'd2, 1'b1, 1'b0, 1'b0, 32'd2);
    reg_check("r3", 5'd3, 32'd2);
    exec("slt_r4", 1'b1, 32'h0041_202A, 32'd1, 1'b1, 1'b0, 1'b0, 32'd1);
    reg_check("r4", 5'd4, 32'd1);
    exec("sll_r5", 1'b1, 32'h0001_2900, 32'h50, 1'b1, 1'b0, 1'b0, 32'h50);
    reg_check("r5", 5'd5, 32'h50);
    exec("addi_r0", 1'b1, 32'h2000_0007, 32'd7, 1'b1, 1'b0, 1'b0, 32'd7);
    reg_check("r0", 5'd0, 32'd0);
    exec("lui_r6", 1'b1, 32'h3C06_ABCD, 32'hABCD_0000, 1'b1, 1'b0, 1'b0, 32'hABCD_0000);
    reg_check("r6", 5'd6, 32'hABCD_0000);

    exec("illegal", 1'b1, 32'hFC00_0000, 32'd0, 1'b0, 1'b1, 1'b0, 32'hABCD_0000);
    exec("nowrite", 1'b0, 32'h2001_0063, 32'd99, 1'b0, 1'b0, 1'b0, 32'hABCD_0000);
    reg_check("r1_hold", 5'd1, 32'd5);
    reg_check("r6_hold", 5'd6, 32'hABCD_0000);

    exec("nor_r10", 1'b1, 32'h0000_5027, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    exec("sra_r11", 1'b1, 32'h0002_5843, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
    exec("ori_r12", 1'b1, 32'h340C_8000, 32'h0000_8000, 1'b1, 1'b0, 1'b0, 32'h0000_8000);
    reg_check("r12", 5'd12, 32'h0000_8000);

    exec("lui_r7", 1'b1, 32'h3C07_7FFF, 32'h7FFF_0000, 1'b1, 1'b0, 1'b0, 32'h7FFF_0000);
`ifdef OVF_TRAP_EN
    exec("add_r8_ovf", 1'b1, 32'h00E7_4020, 32'hFFFE_0000, 1'b0, 1'b0, 1'b1, 32'h7FFF_0000);
    reg_check("r8", 5'd8, 32'd0);
`else
    exec("add_r8_wrap", 1'b1, 32'h00E7_4020, 32'hFFFE_0000, 1'b1, 1'b0, 1'b0, 32'hFFFE_0000);
    reg_check("r8", 5'd8, 32'hFFFE_0000);
`endif
    exec("addu_r9", 1'b1, 32'h00E7_4821, 32'hFFFE_0000, 1'b1, 1'b0, 1'b0, 32'hFFFE_0000);
    reg_check("r9", 5'd9, 32'hFFFE_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
